bcd_display_scanner: RTL and testbench
======================================

BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each digit position stays lit (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-003 SHALL have port rstN  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port bcdAnswer  input  25  {sign, hundredThousands, tenThousands, thousands, hundreds, tens, ones}, 4-bit digits from the binary-to-BCD stage.
REQ-005 SHALL have port load  input  1  one-cycle capture strobe for bcdAnswer.
REQ-006 SHALL have port segments  output  7  {g,f,e,d,c,b,a}, active-low.
REQ-007 SHALL have port digitEnable  output  7  one-hot active-low position select, bit 0 = ones, bit 5 = hundredThousands, bit 6 = sign.

Function
REQ-008 SHALL capture bcdAnswer into a 25-bit hold register on every rising edge with load=1; load=0 SHALL keep the hold register.
REQ-009 SHALL display only the hold register, never bcdAnswer directly.
REQ-010 SHALL keep a prescaler counting 0..SCAN_DIV-1 and wrapping to 0.
REQ-011 SHALL advance the position counter 0,1,...,6,0 on the cycle the prescaler wraps.
REQ-012 SHALL register segments and digitEnable, so outputs reflect pos and hold register values from the previous edge (one-cycle latency).
REQ-013 SHALL drive digitEnable with exactly one bit low, bit[pos], at all times outside reset.
REQ-014 SHALL decode digits 0-9 as standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 SHALL decode digit codes 10-15 as 'E' = 0000110.
REQ-016 SHALL blank (1111111) position p (1..5) when digit p and every higher digit are 0; invalid codes count as nonzero.
REQ-017 SHALL never blank the ones position.
REQ-018 SHALL show '-' (0111111) at position 6 when sign=1 and any digit is nonzero, and blank otherwise; this suppresses negative zero.
REQ-019 SHALL use the new value from the next edge when load coincides with a position advance; the advance itself SHALL be unaffected.
REQ-020 SHALL let load never reset the prescaler or the position counter.
REQ-021 SHALL make repeated load pulses with identical data produce no visible output glitch.

Reset
REQ-022 SHALL, while rstN=0, clear the hold register, prescaler and position to 0, and force segments=1111111 and digitEnable=1111111 immediately (asynchronously).
REQ-023 SHALL, on the first edge after rstN rises, show the ones position with digit '0' (digitEnable=1111110, segments=1000000).
REQ-024 SHALL, on reset mid-scan or mid-load, discard the captured value; no partial capture.

Structure
REQ-025 SHALL place NUM_POS=7, DIGIT_W=4, segment pattern constants (digits, 'E', '-', blank) and the position index type in shared package calc_display_pkg.
REQ-026 SHALL implement the digit-to-segment decode as combinational sub-module seg_decoder (4-bit code in, 7-bit active-low pattern out), instantiated once on the muxed digit.
REQ-027 SHALL compute leading-zero blanking and sign handling in bcd_display_scanner, not in seg_decoder.

Verification (SCAN_DIV=4)
REQ-028 SHALL check that reset is asserted mid-scan -> both outputs read 1111111 asynchronously, and the first post-reset edge gives ones '0'.
REQ-029 SHALL check load 0x0_99_80_01 (998001, sign 0), then scan one full cycle -> ones..hundredThousands show 1,0,0,8,9,9, and sign is blank.
REQ-030 SHALL check load sign=1 with magnitude 42 -> positions 2-5 blank, tens '4', ones '2', sign '-'.
REQ-031 SHALL check load sign=1 with magnitude 0 -> only ones '0' is shown, and sign is blank.
REQ-032 SHALL check digit code 0xB in the tens position -> 'E' at tens, and hundreds and above blank.
REQ-033 SHALL check load asserted on the prescaler-wrap cycle -> position advances normally, new data appears one cycle later, and digitEnable stays one-hot every cycle.

Source files
------------

// File: rtl/calc_display_pkg.sv
// Shared constants and types for the seven-digit calculator display scanner.
// Segment patterns are ordered {g,f,e,d,c,b,a} and are active-low.
package calc_display_pkg;

    localparam int NUM_POS = 7;
    localparam int DIGIT_W = 4;
    localparam int POS_W   = 3;
    localparam int SEG_W   = 7;

    typedef logic [POS_W-1:0] pos_t;

    localparam pos_t SIGN_POS = 3'd6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD digit to active-low seven-segment pattern; codes 10-15 show 'E'.
module seg_decoder
    import calc_display_pkg::*;
(
    input  logic [DIGIT_W-1:0] code_i,
    output logic [SEG_W-1:0]   seg_o
);

    // Digit lookup
    always_comb begin
        case (code_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-position display driver: holds a captured BCD answer and scans
// it one position at a time with leading-zero blanking and a suppressed negative zero.
module bcd_display_scanner
    import calc_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic [NUM_POS*DIGIT_W-DIGIT_W:0]  bcdAnswer,
    input  logic                              load,
    output logic [SEG_W-1:0]                  segments,
    output logic [NUM_POS-1:0]                digitEnable
);

    localparam int HOLD_W = (NUM_POS - 1) * DIGIT_W + 1;
    localparam int NUM_DIG = NUM_POS - 1;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    pos_t               pos_q, pos_d;
    logic [SEG_W-1:0]   seg_q, seg_d;
    logic [NUM_POS-1:0] en_q, en_d;

    logic [NUM_DIG-1:0] dig_nz_s;
    logic [NUM_DIG-1:0] lead_zero_s;
    logic               zero_run_s;
    logic [DIGIT_W-1:0] digit_s;
    logic               blank_s;
    logic [SEG_W-1:0]   dec_seg_s;

    // Capture, prescaler and position sequencing
    always_comb begin
        if (load) begin
            hold_d = bcdAnswer;
        end else begin
            hold_d = hold_q;
        end
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (pos_q == SIGN_POS) begin
                pos_d = 3'd0;
            end else begin
                pos_d = pos_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            pos_d = pos_q;
        end
    end

    // lead_zero_s[p] means digit p and every digit above it are zero
    always_comb begin
        zero_run_s  = 1'b1;
        dig_nz_s    = '0;
        lead_zero_s = '0;
        for (int i = NUM_DIG - 1; i >= 0; i--) begin
            dig_nz_s[i]    = |hold_q[DIGIT_W*i +: DIGIT_W];
            zero_run_s     = zero_run_s & ~dig_nz_s[i];
            lead_zero_s[i] = zero_run_s;
        end
    end

    // Digit mux and per-position blanking
    always_comb begin
        case (pos_q)
            3'd0:    begin digit_s = hold_q[3:0];   blank_s = 1'b0;           end
            3'd1:    begin digit_s = hold_q[7:4];   blank_s = lead_zero_s[1]; end
            3'd2:    begin digit_s = hold_q[11:8];  blank_s = lead_zero_s[2]; end
            3'd3:    begin digit_s = hold_q[15:12]; blank_s = lead_zero_s[3]; end
            3'd4:    begin digit_s = hold_q[19:16]; blank_s = lead_zero_s[4]; end
            3'd5:    begin digit_s = hold_q[23:20]; blank_s = lead_zero_s[5]; end
            default: begin digit_s = 4'd0;          blank_s = 1'b1;           end
        endcase
    end

    seg_decoder u_seg_decoder (
        .code_i (digit_s),
        .seg_o  (dec_seg_s)
    );

    // Output pattern selection; the sign only lights for a nonzero magnitude
    always_comb begin
        if (pos_q == SIGN_POS) begin
            if (hold_q[HOLD_W-1] && (|dig_nz_s)) begin
                seg_d = SEG_DASH;
            end else begin
                seg_d = SEG_BLANK;
            end
        end else if (blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg_s;
        end
        en_d = ~(7'b0000001 << pos_q);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            hold_q <= '0;
            cnt_q  <= '0;
            pos_q  <= 3'd0;
            seg_q  <= SEG_BLANK;
            en_q   <= 7'b1111111;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            seg_q  <= seg_d;
            en_q   <= en_d;
        end
    end

    assign segments    = seg_q;
    assign digitEnable = en_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomised bench for bcd_display_scanner against a digit-level display model.
module tb_bcd_display_scanner;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        load = 1'b0;
    logic [24:0] bcd = 25'd0;
    logic [6:0]  segments;
    logic [6:0]  digitEnable;

    int total = 0;
    int bad   = 0;

    // Model state: edges seen since reset and the value the display is holding
    int          n = 0;
    logic [24:0] mhold = 25'd0;

    localparam logic [6:0] LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
        7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110
    };

    always #5 clk = ~clk;

    bcd_display_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .bcdAnswer   (bcd),
        .load        (load),
        .segments    (segments),
        .digitEnable (digitEnable)
    );

    task automatic check7(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // What position pos shows for a held value h
    function automatic logic [6:0] model_seg(input int pos, input logic [24:0] h);
        int top;
        top = -1;
        for (int i = 0; i < 6; i++) begin
            if (h[4*i +: 4] != 4'd0) top = i;
        end
        if (pos == 6) return (h[24] && top >= 0) ? 7'b0111111 : 7'b1111111;
        if (pos != 0 && pos > top) return 7'b1111111;
        return LUT[h[4*pos +: 4]];
    endfunction

    function automatic logic [24:0] rand_bcd();
        logic [24:0] v;
        int top;
        int d;
        v = 25'd0;
        top = $urandom_range(0, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < top) begin
                if ($urandom_range(0, 15) == 0) d = $urandom_range(10, 15);
                else d = $urandom_range(0, 9);
            end else begin
                d = 0;
            end
            v[4*i +: 4] = d[3:0];
        end
        v[24] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // One clock: advance the model across the edge, then compare 1 time unit later
    task automatic tick();
        logic [6:0] es;
        logic [6:0] ee;
        int pos;
        @(posedge clk);
        if (!rstN) begin
            n = 0;
            mhold = 25'd0;
            es = 7'b1111111;
            ee = 7'b1111111;
        end else begin
            pos = (n / SCAN_DIV) % 7;
            es = model_seg(pos, mhold);
            ee = ~(7'b0000001 << pos);
            if (load) mhold = bcd;
            n++;
        end
        #1;
        check7("segments", segments, es);
        check7("digitEnable", digitEnable, ee);
        if (rstN) begin
            total++;
            if ($countones(~digitEnable) != 1) begin
                bad++;
                $display("FAIL onehot: got %b expected exactly one low bit", digitEnable);
            end
        end
    endtask

    task automatic do_load(input logic [24:0] v);
        bcd = v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_pos(input int p, input logic [6:0] lit, input string name);
        bit found;
        logic [6:0] want;
        found = 1'b0;
        want = ~(7'b0000001 << p);
        for (int k = 0; k < 64 && !found; k++) begin
            tick();
            if (digitEnable == want) begin
                found = 1'b1;
                check7(name, segments, lit);
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL %s: position %0d never selected, got %b required %b", name, p, digitEnable, want);
        end
    endtask

    initial begin
        repeat (3) tick();
        rstN = 1'b1;
        tick();
        check7("first_seg", segments, 7'b1000000);
        check7("first_en", digitEnable, 7'b1111110);

        // Asynchronous reset mid-scan
        do_load(25'h0123456);
        repeat (9) tick();
        #2 rstN = 1'b0;
        #1;
        check7("async_seg", segments, 7'b1111111);
        check7("async_en", digitEnable, 7'b1111111);
        tick();
        tick();
        rstN = 1'b1;
        tick();
        check7("post_rst_seg", segments, 7'b1000000);
        check7("post_rst_en", digitEnable, 7'b1111110);

        // Reset coinciding with a load discards the data
        repeat (5) tick();
        bcd = 25'h0765432;
        load = 1'b1;
        #1 rstN = 1'b0;
        tick();
        load = 1'b0;
        rstN = 1'b1;
        wait_pos(1, 7'b1111111, "discard_tens");
        wait_pos(0, 7'b1000000, "discard_ones");

        do_load(25'h0998001);
        wait_pos(0, 7'b1111001, "998001_p0");
        wait_pos(1, 7'b1000000, "998001_p1");
        wait_pos(2, 7'b1000000, "998001_p2");
        wait_pos(3, 7'b0000000, "998001_p3");
        wait_pos(4, 7'b0010000, "998001_p4");
        wait_pos(5, 7'b0010000, "998001_p5");
        wait_pos(6, 7'b1111111, "998001_sign");

        do_load(25'h1000042);
        wait_pos(0, 7'b0100100, "m42_p0");
        wait_pos(1, 7'b0011001, "m42_p1");
        wait_pos(2, 7'b1111111, "m42_p2");
        wait_pos(5, 7'b1111111, "m42_p5");
        wait_pos(6, 7'b0111111, "m42_sign");

        do_load(25'h1000000);
        wait_pos(0, 7'b1000000, "negzero_p0");
        wait_pos(1, 7'b1111111, "negzero_p1");
        wait_pos(6, 7'b1111111, "negzero_sign");

        do_load(25'h00000B3);
        wait_pos(0, 7'b0110000, "err_p0");
        wait_pos(1, 7'b0000110, "err_p1");
        wait_pos(2, 7'b1111111, "err_p2");

        // Load landing exactly on a prescaler wrap
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < SCAN_DIV && (n % SCAN_DIV) != SCAN_DIV - 1; k++) tick();
            do_load(rand_bcd());
            repeat (3) tick();
        end

        // Random traffic, with repeated identical loads and one reset
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 2) != 0) bcd = rand_bcd();
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (c == 400) rstN = 1'b0;
            if (c == 402) rstN = 1'b1;
            tick();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
